// File: rtl/rv_plic_core.sv
// Interrupt controller core. Each source has a gateway (IDLE/PENDING/ACTIVE) with a saturating
// edge counter and MSI input. Each target picks the highest-priority pending, enabled source.
module rv_plic_core #(
  parameter  int N_SOURCE   = 32,
  parameter  int N_TARGET   = 2,
  parameter  int MAX_PRIO   = 7,
  parameter  int EDGE_CNT_W = 4,
  localparam int PRIOW      = $clog2(MAX_PRIO + 1),
  localparam int SRCW       = $clog2(N_SOURCE + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_SOURCE-1:0]          intr_src_i,
  input  logic [N_SOURCE-1:0]          le_i,
  input  logic                         msi_valid_i,
  input  logic [SRCW-1:0]              msi_id_i,
  input  logic [N_SOURCE*PRIOW-1:0]    prio_i,
  input  logic [N_TARGET*N_SOURCE-1:0] ie_i,
  input  logic [N_TARGET*PRIOW-1:0]    threshold_i,
  input  logic [N_TARGET-1:0]          claim_i,
  input  logic [N_TARGET-1:0]          complete_i,
  input  logic [N_TARGET*SRCW-1:0]     complete_id_i,
  output logic [N_SOURCE-1:0]          ip_o,
  output logic [N_TARGET-1:0]          irq_o,
  output logic [N_TARGET*SRCW-1:0]     irq_id_o,
  output logic [N_TARGET*SRCW-1:0]     claim_id_o
);

  typedef enum logic [1:0] {GW_IDLE, GW_PENDING, GW_ACTIVE} gw_state_t;

  localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [EDGE_CNT_W-1:0] CNT_ONE = EDGE_CNT_W'(1);

  // Per source, which target (at most one) was granted the claim this cycle.
  logic [N_TARGET-1:0] win_by_src [N_SOURCE];

  for (genvar gi = 0; gi < N_SOURCE; gi++) begin : g_src
    localparam logic [SRCW-1:0] SRC_ID = SRCW'(gi + 1);

    gw_state_t             state_reg;
    logic [EDGE_CNT_W-1:0] cnt_reg;
    logic                  prev_reg;
    logic                  evt;
    logic                  claimed;
    logic                  completed;
    logic                  dec;
    logic [N_TARGET-1:0]   win;

    // A claim is granted only while the source is still pending; lowest target index wins.
    always_comb begin
      win       = '0;
      completed = 1'b0;
      for (int t = 0; t < N_TARGET; t++) begin
        if (claim_i[t] && (irq_id_o[t*SRCW +: SRCW] == SRC_ID) &&
            (state_reg == GW_PENDING) && (win == '0)) begin
          win[t] = 1'b1;
        end
        if (complete_i[t] && (complete_id_i[t*SRCW +: SRCW] == SRC_ID)) begin
          completed = 1'b1;
        end
      end
    end

    assign win_by_src[gi] = win;
    assign claimed        = |win;
    assign evt            = (le_i[gi] && intr_src_i[gi] && !prev_reg) ||
                            (msi_valid_i && (msi_id_i == SRC_ID));
    assign dec            = claimed && (cnt_reg != '0);
    assign ip_o[gi]       = (state_reg == GW_PENDING);

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_reg <= GW_IDLE;
        cnt_reg   <= '0;
        prev_reg  <= 1'b0;
      end else begin
        prev_reg <= intr_src_i[gi];
        // An event and a claim in the same cycle cancel out.
        if (evt && !dec && (cnt_reg != CNT_MAX)) begin
          cnt_reg <= cnt_reg + CNT_ONE;
        end else if (!evt && dec) begin
          cnt_reg <= cnt_reg - CNT_ONE;
        end
        case (state_reg)
          GW_IDLE: begin
            if ((!le_i[gi] && intr_src_i[gi]) || (cnt_reg != '0) || evt) begin
              state_reg <= GW_PENDING;
            end
          end
          GW_PENDING: begin
            if (claimed) begin
              state_reg <= GW_ACTIVE;
            end
          end
          GW_ACTIVE: begin
            if (completed) begin
              state_reg <= GW_IDLE;
            end
          end
          default: state_reg <= GW_IDLE;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < N_TARGET; gi++) begin : g_tgt
    logic [PRIOW-1:0] best_prio;
    logic [SRCW-1:0]  best_id;
    logic             granted;
    logic             irq_reg;
    logic [SRCW-1:0]  irq_id_reg;
    logic [SRCW-1:0]  claim_id_reg;

    // Seeding with the threshold excludes prio <= threshold; strict '>' keeps the lowest ID on ties.
    always_comb begin
      best_prio = threshold_i[gi*PRIOW +: PRIOW];
      best_id   = '0;
      for (int k = 0; k < N_SOURCE; k++) begin
        if (ip_o[k] && ie_i[gi*N_SOURCE + k] && (prio_i[k*PRIOW +: PRIOW] > best_prio)) begin
          best_prio = prio_i[k*PRIOW +: PRIOW];
          best_id   = SRCW'(k + 1);
        end
      end
    end

    always_comb begin
      granted = 1'b0;
      for (int k = 0; k < N_SOURCE; k++) begin
        granted = granted | win_by_src[k][gi];
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        irq_reg      <= 1'b0;
        irq_id_reg   <= '0;
        claim_id_reg <= '0;
      end else begin
        irq_reg    <= (best_id != '0);
        irq_id_reg <= best_id;
        if (claim_i[gi]) begin
          claim_id_reg <= granted ? irq_id_reg : '0;
        end
      end
    end

    assign irq_o[gi]                   = irq_reg;
    assign irq_id_o[gi*SRCW +: SRCW]   = irq_id_reg;
    assign claim_id_o[gi*SRCW +: SRCW] = claim_id_reg;
  end

endmodule
